// File: rtl/pll_nco_pkg.sv
// pll_nco_pkg: shared definitions for the pll numerically controlled oscillator.
//   - default widths for the phase accumulator, FCW and output samples
//   - quadrant encoding of the two phase MSBs and the sign rules per quadrant
//   - quarter_sine(): contents of the 64-entry quarter-wave magnitude table,
//     round(127*sin(pi/2*(k+0.5)/64)). The half-step offset keeps every entry
//     in 2..127, so a negated entry never wraps and never produces zero.
package pll_nco_pkg;

    localparam int PHASE_W_DEF = 16;
    localparam int FCW_W_DEF   = 8;
    localparam int OUT_W_DEF   = 8;
    localparam int LUT_AW_DEF  = 6;

    // Quadrant = phase[PHASE_W-1 -: 2]
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,   // 0    .. pi/2
        QUAD_1 = 2'd1,   // pi/2 .. pi
        QUAD_2 = 2'd2,   // pi   .. 3pi/2
        QUAD_3 = 2'd3    // 3pi/2.. 2pi
    } quad_e;

    function automatic logic sin_negate(input quad_e q);
        return (q == QUAD_2) || (q == QUAD_3);
    endfunction

    function automatic logic cos_negate(input quad_e q);
        return (q == QUAD_1) || (q == QUAD_2);
    endfunction

    // Quarter-wave magnitude table, indexed 0..63 (first quarter of a sine).
    function automatic logic [6:0] quarter_sine(input int k);
        logic [6:0] v;
        v = 7'd0;
        case (k)
            0: v = 7'd2;    1: v = 7'd5;    2: v = 7'd8;    3: v = 7'd11;
            4: v = 7'd14;   5: v = 7'd17;   6: v = 7'd20;   7: v = 7'd23;
            8: v = 7'd26;   9: v = 7'd29;  10: v = 7'd32;  11: v = 7'd35;
           12: v = 7'd38;  13: v = 7'd41;  14: v = 7'd44;  15: v = 7'd47;
           16: v = 7'd50;  17: v = 7'd53;  18: v = 7'd56;  19: v = 7'd58;
           20: v = 7'd61;  21: v = 7'd64;  22: v = 7'd67;  23: v = 7'd69;
           24: v = 7'd72;  25: v = 7'd74;  26: v = 7'd77;  27: v = 7'd79;
           28: v = 7'd82;  29: v = 7'd84;  30: v = 7'd86;  31: v = 7'd89;
           32: v = 7'd91;  33: v = 7'd93;  34: v = 7'd95;  35: v = 7'd97;
           36: v = 7'd99;  37: v = 7'd101; 38: v = 7'd103; 39: v = 7'd105;
           40: v = 7'd106; 41: v = 7'd108; 42: v = 7'd110; 43: v = 7'd111;
           44: v = 7'd113; 45: v = 7'd114; 46: v = 7'd115; 47: v = 7'd117;
           48: v = 7'd118; 49: v = 7'd119; 50: v = 7'd120; 51: v = 7'd121;
           52: v = 7'd122; 53: v = 7'd123; 54: v = 7'd124; 55: v = 7'd124;
           56: v = 7'd125; 57: v = 7'd125; 58: v = 7'd126; 59: v = 7'd126;
           60: v = 7'd127; 61: v = 7'd127; 62: v = 7'd127; 63: v = 7'd127;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pll_nco_lut.sv
// pll_nco_lut: quarter-wave magnitude ROM with two independent registered
// read ports (one for the sine address, one for the cosine address).
// Ports:
//   i_clk        clock, rising edge
//   i_sin_addr   sine read address
//   i_cos_addr   cosine read address
//   o_sin_mag    sine magnitude, one cycle after the address
//   o_cos_mag    cosine magnitude, one cycle after the address
// Read data is not reset; validity is tracked by the surrounding pipeline.
module pll_nco_lut
    import pll_nco_pkg::*;
#(
    parameter int AW = LUT_AW_DEF,
    parameter int DW = OUT_W_DEF - 1
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_sin_addr,
    input  logic [AW-1:0] i_cos_addr,
    output logic [DW-1:0] o_sin_mag,
    output logic [DW-1:0] o_cos_mag
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] rom [DEPTH];
    logic [DW-1:0] sin_mag_d, sin_mag_q;
    logic [DW-1:0] cos_mag_d, cos_mag_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign rom[gi] = DW'(quarter_sine(gi));
        end
    endgenerate

    always_comb begin
        sin_mag_d = rom[i_sin_addr];
        cos_mag_d = rom[i_cos_addr];
    end

    always_ff @(posedge i_clk) begin
        sin_mag_q <= sin_mag_d;
        cos_mag_q <= cos_mag_d;
    end

    assign o_sin_mag = sin_mag_q;
    assign o_cos_mag = cos_mag_q;

endmodule

// File: rtl/pll_nco.sv
// pll_nco: numerically controlled oscillator fed by the pll loop filter.
// Integrates an unsigned FCW into a phase accumulator and converts each
// sampled phase into signed sine/cosine through a quarter-wave LUT.
// Three-stage pipeline: phase capture -> LUT read -> sign apply.
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous reset, active-high
//   i_ce         sample strobe, one output sample per high cycle
//   i_fcw        unsigned phase increment per sample
//   i_phase_load load accumulator from i_phase (wins over increment)
//   i_phase      phase value to load
//   o_valid      output sample strobe
//   o_phase      phase that produced the current sample
//   o_sin/o_cos  signed samples; hold their value while o_valid is low
module pll_nco
    import pll_nco_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int FCW_W   = FCW_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int LUT_AW  = LUT_AW_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ce,
    input  logic [FCW_W-1:0]   i_fcw,
    input  logic               i_phase_load,
    input  logic [PHASE_W-1:0] i_phase,
    output logic               o_valid,
    output logic [PHASE_W-1:0] o_phase,
    output logic [OUT_W-1:0]   o_sin,
    output logic [OUT_W-1:0]   o_cos
);

    logic [PHASE_W-1:0] acc_d, acc_q;
    logic [PHASE_W-1:0] p1_d, p1_q;
    logic               v1_d, v1_q;
    logic [PHASE_W-1:0] p2_d, p2_q;
    quad_e              q2_d, q2_q;
    logic               v2_d, v2_q;
    logic               valid_d, valid_q;
    logic [PHASE_W-1:0] phase_d, phase_q;
    logic [OUT_W-1:0]   sin_d, sin_q;
    logic [OUT_W-1:0]   cos_d, cos_q;

    quad_e             q1;
    logic [LUT_AW-1:0] idx, idx_m, sin_addr, cos_addr;
    logic [OUT_W-2:0]  sin_mag, cos_mag;
    logic [OUT_W-1:0]  sin_ext, cos_ext;

    // Odd quadrants run the quarter wave backwards, and cosine is always the
    // mirror of sine within a quadrant. Phase bits below the index are dropped.
    assign q1       = quad_e'(p1_q[PHASE_W-1 -: 2]);
    assign idx      = p1_q[PHASE_W-3 -: LUT_AW];
    assign idx_m    = ~idx;
    assign sin_addr = q1[0] ? idx_m : idx;
    assign cos_addr = q1[0] ? idx   : idx_m;

    pll_nco_lut #(
        .AW (LUT_AW),
        .DW (OUT_W - 1)
    ) u_lut (
        .i_clk      (i_clk),
        .i_sin_addr (sin_addr),
        .i_cos_addr (cos_addr),
        .o_sin_mag  (sin_mag),
        .o_cos_mag  (cos_mag)
    );

    always_comb begin
        // Accumulator: load beats increment; a sample always sees the old value.
        acc_d = acc_q;
        if (i_phase_load) begin
            acc_d = i_phase;
        end else if (i_ce) begin
            acc_d = acc_q + PHASE_W'(i_fcw);
        end

        p1_d = acc_q;
        v1_d = i_ce;

        p2_d = p1_q;
        q2_d = q1;
        v2_d = v1_q;

        sin_ext = {1'b0, sin_mag};
        cos_ext = {1'b0, cos_mag};

        valid_d = v2_q;
        phase_d = phase_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        if (v2_q) begin
            phase_d = p2_q;
            sin_d   = sin_negate(q2_q) ? (OUT_W'(0) - sin_ext) : sin_ext;
            cos_d   = cos_negate(q2_q) ? (OUT_W'(0) - cos_ext) : cos_ext;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc_q   <= '0;
            p1_q    <= '0;
            v1_q    <= 1'b0;
            p2_q    <= '0;
            q2_q    <= QUAD_0;
            v2_q    <= 1'b0;
            valid_q <= 1'b0;
            phase_q <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            p1_q    <= p1_d;
            v1_q    <= v1_d;
            p2_q    <= p2_d;
            q2_q    <= q2_d;
            v2_q    <= v2_d;
            valid_q <= valid_d;
            phase_q <= phase_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
        end
    end

    assign o_valid = valid_q;
    assign o_phase = phase_q;
    assign o_sin   = sin_q;
    assign o_cos   = cos_q;

endmodule
